apb_uart_requester: RTL and testbench
=====================================

APB_UART_REQUESTER -- requirements
Module: apb_uart_requester

Interface
REQ-001 Parameter AddrWidth, default 32, APB address width in bits.
REQ-002 Parameter DataWidth, default 32, APB data width in bits.
REQ-003 Parameter TimeoutCycles, default 16, maximum ACCESS-phase cycles waited for pready_i; legal range is at least 2.
REQ-004 Port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 Port rst_i, input, 1 bit, synchronous active-high reset.
REQ-006 Request ports: req_valid_i in 1; req_ready_o out 1; req_write_i in 1 (1=write); req_addr_i in AddrWidth; req_wdata_i in DataWidth.
REQ-007 Response ports: rsp_valid_o out 1; rsp_ready_i in 1; rsp_rdata_o out DataWidth; rsp_err_o out 1 (pslverr or timeout); rsp_timeout_o out 1.
REQ-008 APB requester ports: psel_o out 1; penable_o out 1; pwrite_o out 1; paddr_o out AddrWidth; pwdata_o out DataWidth; prdata_i in DataWidth; pready_i in 1; pslverr_i in 1.

Function
REQ-009 FSM states are IDLE, SETUP, ACCESS and RESP, with exactly one transaction outstanding.
REQ-010 req_ready_o is 1 only in IDLE; a request is accepted on a cycle with req_valid_i=1 and req_ready_o=1.
REQ-011 On acceptance, write, addr and wdata are registered (wdata forced to 0 for reads) and the FSM moves to SETUP.
REQ-012 SETUP lasts exactly one cycle with psel_o=1 and penable_o=0, then moves to ACCESS.
REQ-013 ACCESS drives psel_o=1 and penable_o=1, and remains in ACCESS while pready_i=0.
REQ-014 paddr_o, pwrite_o and pwdata_o are registered and held stable from SETUP through the final ACCESS cycle.
REQ-015 An ACCESS cycle with pready_i=1 completes the transfer and moves to RESP, capturing the following:
- rsp_rdata_o = prdata_i for reads, 0 for writes;
- rsp_err_o = pslverr_i;
- rsp_timeout_o = 0.
REQ-016 A wait counter clears on entry to ACCESS and increments on each ACCESS cycle with pready_i=0.
REQ-017 When the wait counter equals TimeoutCycles-1 and pready_i=0, the FSM moves to RESP with rsp_err_o=1, rsp_timeout_o=1 and rsp_rdata_o=0.
REQ-018 If pready_i=1 on the timeout cycle, normal completion (REQ-015) takes priority over timeout.
REQ-019 On the transition into RESP, psel_o and penable_o deassert, so neither is 1 in RESP or IDLE.
REQ-020 RESP holds rsp_valid_o=1 with stable response fields until rsp_ready_i=1, then moves to IDLE.
REQ-021 rsp_valid_o is never 1 outside RESP.
REQ-022 A new request is not accepted in the same cycle the response handshake completes.
REQ-023 Latency: with request accepted in cycle 0 and pready_i=1 in the first ACCESS cycle:
- SETUP in cycle 1;
- ACCESS in cycle 2;
- rsp_valid_o=1 in cycle 3.
REQ-024 Minimum request-to-request spacing is 4 cycles.
REQ-025 All outputs are driven from flops, with no combinational path from any input to any output.

Reset
REQ-026 While rst_i=1 at a rising edge, the FSM goes to IDLE and the wait counter clears.
REQ-027 Reset values of all outputs:
- psel_o, penable_o, pwrite_o = 0;
- paddr_o, pwdata_o = 0;
- rsp_valid_o, rsp_err_o, rsp_timeout_o = 0;
- rsp_rdata_o = 0;
- req_ready_o = 1 from the first cycle after reset.
REQ-028 Reset asserted mid-transaction (SETUP, ACCESS or RESP) aborts it: psel_o and penable_o are 0 the cycle after the reset edge, and no response is ever issued for the aborted request.

Verification
REQ-029 Write 0x0000_0041 to 0x0000_1000, pready_i=1 at once -> cycle 1 psel=1/penable=0; cycle 2 psel=1/penable=1/pwrite=1/paddr=0x1000/pwdata=0x41; cycle 3 rsp_valid=1, err=0, rdata=0.
REQ-030 Read 0x0000_1014, pready_i low for 3 ACCESS cycles then high with prdata=0xA5, rsp_ready_i=1 -> ACCESS lasts 4 cycles, addr stable throughout, rsp_rdata=0xA5, err=0, req_ready=1 on the following cycle.
REQ-031 Read with pready_i held 0, TimeoutCycles=16 -> exactly 16 ACCESS cycles, then rsp_valid=1, err=1, timeout=1, rdata=0, psel=0.
REQ-032 Write with pready_i=1 and pslverr_i=1, rsp_ready_i held 0 for 5 cycles -> rsp_valid stays 1 with err=1/timeout=0 unchanged for 6 cycles, and no new request is accepted meanwhile.
REQ-033 pready_i rises on the cycle the wait counter equals TimeoutCycles-1 with prdata=0x5A -> normal completion, rdata=0x5A, timeout=0.
REQ-034 rst_i pulsed for 1 cycle during ACCESS -> next cycle psel=0, penable=0, rsp_valid=0, req_ready=1, and no response appears afterwards.

Source files
------------

// File: rtl/apb_uart_requester_if.sv
// Bundles the request, response and APB requester signals of apb_uart_requester.
// Signal suffixes are from the requester's point of view.
interface apb_uart_requester_if #(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32
);
   logic                 req_valid_i;
   logic                 req_ready_o;
   logic                 req_write_i;
   logic [AddrWidth-1:0] req_addr_i;
   logic [DataWidth-1:0] req_wdata_i;

   logic                 rsp_valid_o;
   logic                 rsp_ready_i;
   logic [DataWidth-1:0] rsp_rdata_o;
   logic                 rsp_err_o;
   logic                 rsp_timeout_o;

   logic                 psel_o;
   logic                 penable_o;
   logic                 pwrite_o;
   logic [AddrWidth-1:0] paddr_o;
   logic [DataWidth-1:0] pwdata_o;
   logic [DataWidth-1:0] prdata_i;
   logic                 pready_i;
   logic                 pslverr_i;

   modport master (
      input  req_valid_i, req_write_i, req_addr_i, req_wdata_i,
      output req_ready_o,
      output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
      input  rsp_ready_i,
      output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
      input  prdata_i, pready_i, pslverr_i
   );

   modport slave (
      output req_valid_i, req_write_i, req_addr_i, req_wdata_i,
      input  req_ready_o,
      input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
      output rsp_ready_i,
      input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
      output prdata_i, pready_i, pslverr_i
   );
endinterface

// File: rtl/apb_uart_requester.sv
// Single-outstanding APB requester: takes one request, runs SETUP/ACCESS with a
// bounded wait on pready, and holds the response until it is accepted.
module apb_uart_requester #(
   parameter int AddrWidth     = 32,
   parameter int DataWidth     = 32,
   parameter int TimeoutCycles = 16
) (
   input logic                  clk_i,
   input logic                  rst_i,
   apb_uart_requester_if.master bus
);

   localparam int WaitWidth = $clog2(TimeoutCycles);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

   state_e               state_q;
   logic [WaitWidth-1:0] wait_q;
   logic                 req_ready_q;
   logic                 psel_q;
   logic                 penable_q;
   logic                 pwrite_q;
   logic [AddrWidth-1:0] paddr_q;
   logic [DataWidth-1:0] pwdata_q;
   logic                 rsp_valid_q;
   logic [DataWidth-1:0] rsp_rdata_q;
   logic                 rsp_err_q;
   logic                 rsp_timeout_q;

   // NOTE: every output is a flop updated with <= in this one block, so no
   // input can reach an output combinationally and the registers update together.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         wait_q        <= '0;
         req_ready_q   <= 1'b1;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.req_valid_i) begin
                  pwrite_q    <= bus.req_write_i;
                  paddr_q     <= bus.req_addr_i;
                  pwdata_q    <= bus.req_write_i ? bus.req_wdata_i : '0;
                  psel_q      <= 1'b1;
                  penable_q   <= 1'b0;
                  req_ready_q <= 1'b0;
                  state_q     <= SETUP;
               end
            end
            SETUP: begin
               penable_q <= 1'b1;
               wait_q    <= '0;
               state_q   <= ACCESS;
            end
            ACCESS: begin
               // A ready completer wins over a timeout landing on the same cycle.
               if (bus.pready_i) begin
                  psel_q        <= 1'b0;
                  penable_q     <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  rsp_rdata_q   <= pwrite_q ? '0 : bus.prdata_i;
                  rsp_err_q     <= bus.pslverr_i;
                  rsp_timeout_q <= 1'b0;
                  state_q       <= RESP;
               end else if (wait_q == WaitWidth'(TimeoutCycles - 1)) begin
                  psel_q        <= 1'b0;
                  penable_q     <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  rsp_rdata_q   <= '0;
                  rsp_err_q     <= 1'b1;
                  rsp_timeout_q <= 1'b1;
                  state_q       <= RESP;
               end else begin
                  wait_q <= wait_q + 1'b1;
               end
            end
            RESP: begin
               if (bus.rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready_o   = req_ready_q;
   assign bus.psel_o        = psel_q;
   assign bus.penable_o     = penable_q;
   assign bus.pwrite_o      = pwrite_q;
   assign bus.paddr_o       = paddr_q;
   assign bus.pwdata_o      = pwdata_q;
   assign bus.rsp_valid_o   = rsp_valid_q;
   assign bus.rsp_rdata_o   = rsp_rdata_q;
   assign bus.rsp_err_o     = rsp_err_q;
   assign bus.rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_apb_uart_requester.sv
// Self-checking bench for apb_uart_requester: a per-cycle vector table for the
// basic write/read flows, then directed sequences for timeout, backpressure and reset.
module tb_apb_uart_requester;

   localparam int NV = 12;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   n_cmp  = 0;
   int   n_fail = 0;

   apb_uart_requester_if #(.AddrWidth(32), .DataWidth(32)) bus ();

   apb_uart_requester #(
      .AddrWidth    (32),
      .DataWidth    (32),
      .TimeoutCycles(16)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .bus  (bus)
   );

   always #5 clk_i = ~clk_i;

   // Inputs applied before an edge; expectations are the outputs after it.
   typedef struct {
      logic        rst, req_valid, req_write;
      logic [31:0] addr, wdata;
      logic        pready, pslverr;
      logic [31:0] prdata;
      logic        rsp_ready;
      logic        e_req_ready, e_psel, e_penable, e_rsp_valid;
      logic        chk_bus, e_pwrite;
      logic [31:0] e_paddr, e_pwdata;
      logic        chk_rsp, e_err, e_tmo;
      logic [31:0] e_rdata;
   } vec_t;

   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_req(input logic valid, input logic write, input logic [31:0] addr,
                            input logic [31:0] wdata);
      bus.req_valid_i = valid;
      bus.req_write_i = write;
      bus.req_addr_i  = addr;
      bus.req_wdata_i = wdata;
   endtask

   initial begin
      int n_acc;

      //        rst rv wr addr           wdata          prdy slv prdata        rrdy  rr ps pe rv  cb pw paddr         pwdata      cr er to rdata
      vecs[0]  = '{0, 1, 1, 32'h0000_1000, 32'h0000_0041, 1, 0, 32'h0,         0,    0, 1, 0, 0,  1, 1, 32'h1000, 32'h41, 0, 0, 0, 32'h0};
      vecs[1]  = '{0, 0, 0, 32'hFFFF_FFFF, 32'h0000_0099, 1, 0, 32'h0,         0,    0, 1, 1, 0,  1, 1, 32'h1000, 32'h41, 0, 0, 0, 32'h0};
      vecs[2]  = '{0, 0, 0, 32'h0,         32'h0,         1, 0, 32'h1234,      0,    0, 0, 0, 1,  0, 0, 32'h0,    32'h0,  1, 0, 0, 32'h0};
      vecs[3]  = '{0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         1,    1, 0, 0, 0,  0, 0, 32'h0,    32'h0,  0, 0, 0, 32'h0};
      vecs[4]  = '{0, 1, 0, 32'h0000_1014, 32'hDEAD_BEEF, 0, 0, 32'h0,         1,    0, 1, 0, 0,  1, 0, 32'h1014, 32'h0,  0, 0, 0, 32'h0};
      vecs[5]  = '{0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         1,    0, 1, 1, 0,  1, 0, 32'h1014, 32'h0,  0, 0, 0, 32'h0};
      vecs[6]  = '{0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         1,    0, 1, 1, 0,  1, 0, 32'h1014, 32'h0,  0, 0, 0, 32'h0};
      vecs[7]  = '{0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         1,    0, 1, 1, 0,  1, 0, 32'h1014, 32'h0,  0, 0, 0, 32'h0};
      vecs[8]  = '{0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         1,    0, 1, 1, 0,  1, 0, 32'h1014, 32'h0,  0, 0, 0, 32'h0};
      vecs[9]  = '{0, 0, 0, 32'h0,         32'h0,         1, 0, 32'h0000_00A5, 1,    0, 0, 0, 1,  0, 0, 32'h0,    32'h0,  1, 0, 0, 32'hA5};
      vecs[10] = '{0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0000_0077, 1,    1, 0, 0, 0,  0, 0, 32'h0,    32'h0,  0, 0, 0, 32'h0};
      vecs[11] = '{0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         0,    1, 0, 0, 0,  0, 0, 32'h0,    32'h0,  0, 0, 0, 32'h0};

      drive_req(1'b0, 1'b0, 32'h0, 32'h0);
      bus.rsp_ready_i = 1'b0;
      bus.prdata_i    = 32'h0;
      bus.pready_i    = 1'b0;
      bus.pslverr_i   = 1'b0;

      // Reset values
      tick();
      tick();
      rst_i = 1'b0;
      tick();
      check("rst req_ready", 32'(bus.req_ready_o), 32'd1);
      check("rst psel",      32'(bus.psel_o),      32'd0);
      check("rst penable",   32'(bus.penable_o),   32'd0);
      check("rst pwrite",    32'(bus.pwrite_o),    32'd0);
      check("rst paddr",     bus.paddr_o,          32'h0);
      check("rst pwdata",    bus.pwdata_o,         32'h0);
      check("rst rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
      check("rst rsp_err",   32'(bus.rsp_err_o),   32'd0);
      check("rst rsp_tmo",   32'(bus.rsp_timeout_o), 32'd0);
      check("rst rsp_rdata", bus.rsp_rdata_o,      32'h0);

      // Basic write with zero wait, then read with three wait cycles
      for (int i = 0; i < NV; i++) begin
         rst_i = vecs[i].rst;
         drive_req(vecs[i].req_valid, vecs[i].req_write, vecs[i].addr, vecs[i].wdata);
         bus.pready_i    = vecs[i].pready;
         bus.pslverr_i   = vecs[i].pslverr;
         bus.prdata_i    = vecs[i].prdata;
         bus.rsp_ready_i = vecs[i].rsp_ready;
         tick();
         check($sformatf("v%0d req_ready", i), 32'(bus.req_ready_o), 32'(vecs[i].e_req_ready));
         check($sformatf("v%0d psel", i),      32'(bus.psel_o),      32'(vecs[i].e_psel));
         check($sformatf("v%0d penable", i),   32'(bus.penable_o),   32'(vecs[i].e_penable));
         check($sformatf("v%0d rsp_valid", i), 32'(bus.rsp_valid_o), 32'(vecs[i].e_rsp_valid));
         if (vecs[i].chk_bus) begin
            check($sformatf("v%0d pwrite", i), 32'(bus.pwrite_o), 32'(vecs[i].e_pwrite));
            check($sformatf("v%0d paddr", i),  bus.paddr_o,       vecs[i].e_paddr);
            check($sformatf("v%0d pwdata", i), bus.pwdata_o,      vecs[i].e_pwdata);
         end
         if (vecs[i].chk_rsp) begin
            check($sformatf("v%0d rsp_err", i),   32'(bus.rsp_err_o),     32'(vecs[i].e_err));
            check($sformatf("v%0d rsp_tmo", i),   32'(bus.rsp_timeout_o), 32'(vecs[i].e_tmo));
            check($sformatf("v%0d rsp_rdata", i), bus.rsp_rdata_o,        vecs[i].e_rdata);
         end
      end

      // Timeout: pready never rises, expect exactly 16 ACCESS cycles
      drive_req(1'b1, 1'b0, 32'h0000_2000, 32'h0);
      bus.pready_i    = 1'b0;
      bus.rsp_ready_i = 1'b0;
      tick();
      check("to setup psel", 32'(bus.psel_o), 32'd1);
      drive_req(1'b0, 1'b0, 32'h0, 32'h0);
      n_acc = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (bus.psel_o && bus.penable_o) n_acc++;
         else break;
      end
      check("to access cycles", 32'(n_acc), 32'd16);
      check("to rsp_valid", 32'(bus.rsp_valid_o),   32'd1);
      check("to rsp_err",   32'(bus.rsp_err_o),     32'd1);
      check("to rsp_tmo",   32'(bus.rsp_timeout_o), 32'd1);
      check("to rsp_rdata", bus.rsp_rdata_o,        32'h0);
      check("to psel",      32'(bus.psel_o),        32'd0);
      check("to penable",   32'(bus.penable_o),     32'd0);
      bus.rsp_ready_i = 1'b1;
      tick();
      check("to done req_ready", 32'(bus.req_ready_o), 32'd1);
      check("to done rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
      bus.rsp_ready_i = 1'b0;

      // Slave error with response backpressure; a pending request must wait
      drive_req(1'b1, 1'b1, 32'h0000_3000, 32'h0000_0055);
      bus.pready_i  = 1'b1;
      bus.pslverr_i = 1'b1;
      tick();
      drive_req(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      tick();
      drive_req(1'b1, 1'b0, 32'h0000_4000, 32'h0);
      for (int k = 0; k < 6; k++) begin
         check($sformatf("bp%0d rsp_valid", k), 32'(bus.rsp_valid_o),   32'd1);
         check($sformatf("bp%0d rsp_err", k),   32'(bus.rsp_err_o),     32'd1);
         check($sformatf("bp%0d rsp_tmo", k),   32'(bus.rsp_timeout_o), 32'd0);
         check($sformatf("bp%0d req_ready", k), 32'(bus.req_ready_o),   32'd0);
         check($sformatf("bp%0d psel", k),      32'(bus.psel_o),        32'd0);
         if (k < 5) tick();
      end
      bus.rsp_ready_i = 1'b1;
      tick();
      check("bp handshake psel",      32'(bus.psel_o),      32'd0);
      check("bp handshake req_ready", 32'(bus.req_ready_o), 32'd1);
      check("bp handshake rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
      drive_req(1'b0, 1'b0, 32'h0, 32'h0);
      bus.rsp_ready_i = 1'b0;
      bus.pslverr_i   = 1'b0;
      bus.pready_i    = 1'b0;
      tick();
      check("bp idle psel", 32'(bus.psel_o), 32'd0);

      // pready rises on the last allowed wait cycle: normal completion wins
      drive_req(1'b1, 1'b0, 32'h0000_5000, 32'h0);
      tick();
      drive_req(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      for (int k = 0; k < 15; k++) tick();
      check("edge still access", 32'(bus.psel_o && bus.penable_o), 32'd1);
      bus.pready_i = 1'b1;
      bus.prdata_i = 32'h0000_005A;
      tick();
      check("edge rsp_valid", 32'(bus.rsp_valid_o),   32'd1);
      check("edge rsp_rdata", bus.rsp_rdata_o,        32'h5A);
      check("edge rsp_tmo",   32'(bus.rsp_timeout_o), 32'd0);
      check("edge rsp_err",   32'(bus.rsp_err_o),     32'd0);
      bus.pready_i    = 1'b0;
      bus.rsp_ready_i = 1'b1;
      tick();
      bus.rsp_ready_i = 1'b0;

      // Reset pulse during ACCESS aborts the transfer for good
      drive_req(1'b1, 1'b0, 32'h0000_6000, 32'h0);
      tick();
      drive_req(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      tick();
      check("abort in access", 32'(bus.psel_o && bus.penable_o), 32'd1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check("abort psel",      32'(bus.psel_o),      32'd0);
      check("abort penable",   32'(bus.penable_o),   32'd0);
      check("abort rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
      check("abort req_ready", 32'(bus.req_ready_o), 32'd1);
      bus.pready_i = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         check($sformatf("abort after%0d rsp_valid", k), 32'(bus.rsp_valid_o), 32'd0);
         check($sformatf("abort after%0d psel", k),      32'(bus.psel_o),      32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
